spi_accel_slave: RTL
====================

Name: spi_accel_slave

Overview:
Synthesizable, parametrised SPI slave that emulates an accelerometer register file. It decodes the READ (0x0B) and WRITE (0x0A) command protocol, then an 8-bit address, then unbounded bursts with address auto-increment. Writes are stored, and all four SPI modes are supported. A host-side port lets the system preload and inspect registers. The block sits under the system bench/SoC as the sensor model attached to the master's MISO/MOSI/CS/SCLK.

Parameters:
NUM_REGS, 32, number of 8-bit registers (2..256)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
CMD_READ, 8'h0B, read command byte
CMD_WRITE, 8'h0A, write command byte

Ports:
clk  input  1  system clock; every flop is clocked on its rising edge
resetn  input  1  synchronous, active-low reset
SCLK  input  1  SPI clock, asynchronous to clk
CS  input  1  chip select, active low, asynchronous
MOSI  input  1  master-out data
MISO  output  1  slave-out data; driven 0 when not returning read data
host_we  input  1  host register write strobe
host_addr  input  8  host register address (read and write)
host_wdata  input  8  host write data
host_rdata  output  8  combinational read of reg[host_addr]; 0 when host_addr >= NUM_REGS
spi_wr_pulse  output  1  one-cycle pulse when an SPI data byte is committed to a register
err_cmd  output  1  one-cycle pulse when an unknown command byte completes
xfer_done  output  1  one-cycle pulse when CS deasserts after at least 1 bit
byte_cnt  output  8  data bytes moved in the last transaction (saturates at 255); valid with xfer_done, holds until next

Behaviour:
- Reset (resetn=0 at a clk edge): reg[i] = i[7:0]; FSM = IDLE; MISO=0; byte_cnt=0; all pulses 0; synchronizers cleared to idle levels (SCLK=CPOL, CS=1).
- Input synchronization: SCLK, CS and MOSI each pass through 2 flops. Edges are detected on the synchronized SCLK. SCLK period must be >= 8 clk cycles.
- Sample edge: leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge is the opposite edge.
- Edge and CS gating: edges are honoured only while synced CS=0. A synced CS rising edge forces IDLE from any state, discards any partial byte, and sets MISO=0.
- FSM: IDLE -> CMD on CS falling; CMD -> ADDR after 8 sampled bits. Command byte == CMD_READ or CMD_WRITE is latched; any other value pulses err_cmd and the FSM enters IGNORE.
- ADDR: after 8 bits, ADDR latches the address and moves to RD or WR.
- RD: the MSB of reg[addr] is put on MISO at the shift edge following the last address bit. For CPHA=0 the next byte's MSB is presented at the shift edge after bit 0 of the previous byte. Each completed byte increments byte_cnt and the address.
- WR: after 8 sampled bits the byte is committed to reg[addr] (spi_wr_pulse=1 for one cycle); then byte_cnt and the address increment.
- IGNORE: MOSI is ignored and MISO=0 until CS deasserts.
- Address increment: next = (addr == NUM_REGS-1) ? 0 : addr+1 (8-bit). Out-of-range address (>= NUM_REGS): reads return 0x00, writes are dropped with no spi_wr_pulse, and the increment is still applied.
- Simultaneous write: if host_we and an SPI commit hit the same register in the same clk cycle, the SPI data wins. Different addresses both complete.
- CS framing: xfer_done pulses 1 cycle after synced CS rises, only if at least 1 bit was sampled. A CS glitch with no SCLK edges produces no pulse.
- Reset mid-transaction: returns to IDLE immediately, register contents are reinitialized, and SPI activity is ignored until CS is seen high then low.
- CPOL=1: edge polarity inverts; bit behaviour is otherwise identical.

Test Plan:
- Mode 0, after reset: READ cmd 0x0B, addr 0x03, 4 data bytes -> MISO returns 0x03, 0x04, 0x05, 0x06; xfer_done with byte_cnt=4.
- WRITE 0x0A, addr 0x10, data 0xA5, 0x5A; then READ from 0x10 for 2 bytes -> returns 0xA5, 0x5A; spi_wr_pulse seen twice; host_rdata at 0x11 = 0x5A.
- Wrap: NUM_REGS=32, READ from addr 0x1E, 3 bytes -> returns 0x1E, 0x1F, 0x00.
- Command 0x77 -> err_cmd pulses once; MISO stays 0 for 16 further clocks; registers unchanged.
- CS raised after 5 bits of a WRITE data byte -> target register unchanged; next READ transaction behaves normally.
- CPOL=1/CPHA=1 instance: READ addr 0x07, 2 bytes -> 0x07, 0x08; host_we to 0x07 in the same cycle as an SPI write of 0x3C to 0x07 -> reg[0x07]=0x3C.

Source files
------------

// File: rtl/spi_accel_slave.sv
// SPI slave modelling an accelerometer register file.
// READ/WRITE command, 8-bit address, auto-incrementing bursts, all SPI modes.
module spi_accel_slave #(
   parameter int         NUM_REGS  = 32,
   parameter bit         CPOL      = 1'b0,
   parameter bit         CPHA      = 1'b0,
   parameter logic [7:0] CMD_READ  = 8'h0B,
   parameter logic [7:0] CMD_WRITE = 8'h0A
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       SCLK,
   input  logic       CS,
   input  logic       MOSI,
   output logic       MISO,
   input  logic       host_we,
   input  logic [7:0] host_addr,
   input  logic [7:0] host_wdata,
   output logic [7:0] host_rdata,
   output logic       spi_wr_pulse,
   output logic       err_cmd,
   output logic       xfer_done,
   output logic [7:0] byte_cnt
);

   localparam int         AW   = $clog2(NUM_REGS);
   localparam logic [8:0] NREG = 9'(NUM_REGS);
   localparam logic [7:0] LAST = 8'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_IGN
   } state_t;

   state_t     state_q, state_d;
   logic       sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d;
   logic       sclk_p_q, sclk_p_d;
   logic       cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
   logic       cs_p_q, cs_p_d;
   logic       mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
   logic       fill_q, fill_d, armed_q, armed_d;
   logic [2:0] bits_q, bits_d;
   logic [6:0] sh_q, sh_d;
   logic [6:0] tx_q, tx_d;
   logic       miso_q, miso_d;
   logic [7:0] addr_q, addr_d;
   logic       cmd_rd_q, cmd_rd_d;
   logic [7:0] cnt_q, cnt_d;
   logic       seen_q, seen_d;
   logic [7:0] byte_cnt_q, byte_cnt_d;
   logic       wr_pulse_q, wr_pulse_d;
   logic       err_q, err_d;
   logic       done_q, done_d;
   logic [7:0] regs_q [NUM_REGS];
   logic [7:0] regs_d [NUM_REGS];

   logic       lead, trail, samp, shft;
   logic       cs_fall, cs_rise, in_frame, byte_done;
   logic       host_ok, addr_ok;
   logic [7:0] rx_byte, rd_byte, addr_inc, cnt_inc;

   assign host_ok    = {1'b0, host_addr} < NREG;
   assign addr_ok    = {1'b0, addr_q} < NREG;
   assign host_rdata = host_ok ? regs_q[host_addr[AW-1:0]] : 8'h00;
   assign rd_byte    = addr_ok ? regs_q[addr_q[AW-1:0]] : 8'h00;
   assign addr_inc   = (addr_q == LAST) ? 8'h00 : addr_q + 8'h01;
   assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'h01;
   assign rx_byte    = {sh_q, mosi_s2_q};

   assign MISO         = miso_q;
   assign spi_wr_pulse = wr_pulse_q;
   assign err_cmd      = err_q;
   assign xfer_done    = done_q;
   assign byte_cnt     = byte_cnt_q;

   always_comb begin
      sclk_s1_d  = SCLK;
      sclk_s2_d  = sclk_s1_q;
      sclk_p_d   = sclk_s2_q;
      cs_s1_d    = CS;
      cs_s2_d    = cs_s1_q;
      cs_p_d     = cs_s2_q;
      mosi_s1_d  = MOSI;
      mosi_s2_d  = mosi_s1_q;
      fill_d     = 1'b1;
      // only a CS high genuinely observed after reset may arm a new frame
      armed_d    = armed_q | (fill_q & cs_s1_q);
      state_d    = state_q;
      bits_d     = bits_q;
      sh_d       = sh_q;
      tx_d       = tx_q;
      miso_d     = miso_q;
      addr_d     = addr_q;
      cmd_rd_d   = cmd_rd_q;
      cnt_d      = cnt_q;
      seen_d     = seen_q;
      byte_cnt_d = byte_cnt_q;
      wr_pulse_d = 1'b0;
      err_d      = 1'b0;
      done_d     = 1'b0;
      regs_d     = regs_q;

      lead      = (sclk_s2_q != CPOL) && (sclk_p_q == CPOL);
      trail     = (sclk_s2_q == CPOL) && (sclk_p_q != CPOL);
      samp      = !cs_s2_q && (CPHA ? trail : lead);
      shft      = !cs_s2_q && (CPHA ? lead : trail);
      cs_fall   = cs_p_q && !cs_s2_q;
      cs_rise   = !cs_p_q && cs_s2_q;
      in_frame  = (state_q != S_IDLE) && (state_q != S_IGN);
      byte_done = samp && in_frame && (bits_q == 3'd7);

      if (host_we && host_ok) begin
         regs_d[host_addr[AW-1:0]] = host_wdata;
      end

      if (cs_rise) begin
         state_d = S_IDLE;
         bits_d  = 3'd0;
         miso_d  = 1'b0;
         seen_d  = 1'b0;
         if (seen_q) begin
            done_d     = 1'b1;
            byte_cnt_d = cnt_q;
         end
      end else begin
         if (samp && in_frame) begin
            sh_d   = rx_byte[6:0];
            bits_d = bits_q + 3'd1;
            seen_d = 1'b1;
         end
         unique case (state_q)
            S_IDLE: begin
               if (cs_fall && armed_q) begin
                  state_d = S_CMD;
                  bits_d  = 3'd0;
                  cnt_d   = 8'h00;
                  seen_d  = 1'b0;
                  miso_d  = 1'b0;
               end
            end
            S_CMD: begin
               if (byte_done) begin
                  if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
                     cmd_rd_d = (rx_byte == CMD_READ);
                     state_d  = S_ADDR;
                  end else begin
                     err_d   = 1'b1;
                     state_d = S_IGN;
                  end
               end
            end
            S_ADDR: begin
               if (byte_done) begin
                  addr_d  = rx_byte;
                  state_d = cmd_rd_q ? S_RD : S_WR;
               end
            end
            S_RD: begin
               if (byte_done) begin
                  addr_d = addr_inc;
                  cnt_d  = cnt_inc;
               end
               // byte boundary: present MSB of the (already advanced) address
               if (shft) begin
                  if (bits_q == 3'd0) begin
                     miso_d = rd_byte[7];
                     tx_d   = rd_byte[6:0];
                  end else begin
                     miso_d = tx_q[6];
                     tx_d   = {tx_q[5:0], 1'b0};
                  end
               end
            end
            S_WR: begin
               if (byte_done) begin
                  if (addr_ok) begin
                     regs_d[addr_q[AW-1:0]] = rx_byte;
                     wr_pulse_d             = 1'b1;
                  end
                  addr_d = addr_inc;
                  cnt_d  = cnt_inc;
               end
            end
            S_IGN: miso_d = 1'b0;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         sclk_s1_q  <= CPOL;
         sclk_s2_q  <= CPOL;
         sclk_p_q   <= CPOL;
         cs_s1_q    <= 1'b1;
         cs_s2_q    <= 1'b1;
         cs_p_q     <= 1'b1;
         mosi_s1_q  <= 1'b0;
         mosi_s2_q  <= 1'b0;
         fill_q     <= 1'b0;
         armed_q    <= 1'b0;
         bits_q     <= 3'd0;
         sh_q       <= '0;
         tx_q       <= '0;
         miso_q     <= 1'b0;
         addr_q     <= 8'h00;
         cmd_rd_q   <= 1'b0;
         cnt_q      <= 8'h00;
         seen_q     <= 1'b0;
         byte_cnt_q <= 8'h00;
         wr_pulse_q <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= 8'(i);
         end
      end else begin
         state_q    <= state_d;
         sclk_s1_q  <= sclk_s1_d;
         sclk_s2_q  <= sclk_s2_d;
         sclk_p_q   <= sclk_p_d;
         cs_s1_q    <= cs_s1_d;
         cs_s2_q    <= cs_s2_d;
         cs_p_q     <= cs_p_d;
         mosi_s1_q  <= mosi_s1_d;
         mosi_s2_q  <= mosi_s2_d;
         fill_q     <= fill_d;
         armed_q    <= armed_d;
         bits_q     <= bits_d;
         sh_q       <= sh_d;
         tx_q       <= tx_d;
         miso_q     <= miso_d;
         addr_q     <= addr_d;
         cmd_rd_q   <= cmd_rd_d;
         cnt_q      <= cnt_d;
         seen_q     <= seen_d;
         byte_cnt_q <= byte_cnt_d;
         wr_pulse_q <= wr_pulse_d;
         err_q      <= err_d;
         done_q     <= done_d;
         regs_q     <= regs_d;
      end
   end

endmodule
